if_fetch: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register and feeds it Ins and PC_P1.
- Owns the word-addressed PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Tolerates multi-cycle memory latency, holds under ID stall, and redirects on a taken branch/jump resolved in ID.
- Emits a NOP bubble whenever no valid instruction is available.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/if_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//   WORD_W           - datapath / word-address width
//   word_t           - one instruction word or word address
//   fetch_state_e    - instruction-fetch control states
//   NOP_WORD         - instruction word used for bubbles and flushes
//   DEFAULT_RESET_PC - default PC loaded on reset
package pipe_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // ST_FETCH   : request outstanding (or about to be), normal operation
  // ST_FULL    : an acked instruction is parked in the skid buffer under stall
  // ST_DISCARD : the outstanding request is stale because of a redirect
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_FULL    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam word_t NOP_WORD         = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage. Owns the word-addressed PC, keeps at most one
// request in flight to instruction memory over a req/ack handshake, absorbs
// an ID stall with a one-entry skid buffer and redirects on a taken
// branch/jump resolved in ID. A NOP bubble is emitted whenever no valid
// instruction is available.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   Stall_ID      - hazard stall from ID (also holds IF/ID)
//   ID_PCSrc      - taken branch/jump in ID, only acted on when ~Stall_ID
//   ID_Target_PC  - redirect target word address
//   imem_req      - fetch request, held until imem_ack
//   imem_addr     - word address of the outstanding request
//   imem_ack      - one-cycle response pulse, imem_rdata valid with it
//   imem_rdata    - instruction word from memory
//   Ins, PC_P1    - registered instruction and its PC+1 to IF/ID
//   IF_Valid      - registered, 1 when Ins/PC_P1 hold a real instruction
module if_fetch
  import pipe_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INS  = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall_ID,
  input  logic              ID_PCSrc,
  input  logic [WORD_W-1:0] ID_Target_PC,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] Ins,
  output logic [WORD_W-1:0] PC_P1,
  output logic              IF_Valid
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        redir_pc_q, redir_pc_d;
  word_t        buf_ins_q, buf_ins_d;
  word_t        buf_pc_p1_q, buf_pc_p1_d;
  word_t        ins_q, ins_d;
  word_t        pc_p1_q, pc_p1_d;
  logic         valid_q, valid_d;

  logic         redirect;
  logic         load_bubble;
  word_t        pc_inc;

  // A stalled ID must not act on its branch: the branch will be re-presented.
  assign redirect = ID_PCSrc & ~Stall_ID;
  assign pc_inc   = pc_q + 32'd1;  // wraps modulo 2^32

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      redir_pc_q  <= '0;
      // NOTE: the skid buffer is only two registers, so it is reset like any
      // other state; no stale word can ever surface after reset.
      buf_ins_q   <= NOP_INS;
      buf_pc_p1_q <= '0;
      ins_q       <= NOP_INS;
      pc_p1_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_pc_q  <= redir_pc_d;
      buf_ins_q   <= buf_ins_d;
      buf_pc_p1_q <= buf_pc_p1_d;
      ins_q       <= ins_d;
      pc_p1_q     <= pc_p1_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    // NOTE: every target gets a hold default first, so no path through the
    // case below can leave a variable unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    redir_pc_d  = redir_pc_q;
    buf_ins_d   = buf_ins_q;
    buf_pc_p1_d = buf_pc_p1_q;
    ins_d       = ins_q;
    pc_p1_d     = pc_p1_q;
    valid_d     = valid_q;
    load_bubble = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          load_bubble = 1'b1;
          if (imem_ack) begin
            pc_d = ID_Target_PC;  // response belongs to the wrong path
          end else begin
            redir_pc_d = ID_Target_PC;
            state_d    = ST_DISCARD;
          end
        end else if (imem_ack && !Stall_ID) begin
          ins_d   = imem_rdata;
          pc_p1_d = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end else if (imem_ack) begin
          // ID is stalled: park the word, outputs keep the held instruction.
          buf_ins_d   = imem_rdata;
          buf_pc_p1_d = pc_inc;
          pc_d        = pc_inc;
          state_d     = ST_FULL;
        end else if (!Stall_ID) begin
          load_bubble = 1'b1;
        end
      end

      ST_FULL: begin
        if (redirect) begin
          load_bubble = 1'b1;
          pc_d        = ID_Target_PC;
          state_d     = ST_FETCH;
        end else if (!Stall_ID) begin
          ins_d   = buf_ins_q;
          pc_p1_d = buf_pc_p1_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        // The stale request stays on the bus until it is acked and dropped.
        if (imem_ack) begin
          pc_d    = redirect ? ID_Target_PC : redir_pc_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          redir_pc_d = ID_Target_PC;  // latest target wins
        end
        load_bubble = !Stall_ID;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (load_bubble) begin
      ins_d   = NOP_INS;
      pc_p1_d = '0;
      valid_d = 1'b0;
    end
  end

  // Handshake outputs, purely from registered state
  always_comb begin
    imem_req  = (state_q != ST_FULL);
    imem_addr = pc_q;
  end

  assign Ins      = ins_q;
  assign PC_P1    = pc_p1_q;
  assign IF_Valid = valid_q;

endmodule
